// File: rtl/mips_pkg.sv
// Shared MMIO map, timer control-bit layout and struct for the MIPS data-memory stage.
package mips_pkg;

    localparam logic [31:0] MMIO_BASE      = 32'h8000_0000;

    localparam logic [31:0] MMIO_GPIO_OUT  = 32'h0000_0000;
    localparam logic [31:0] MMIO_GPIO_IN   = 32'h0000_0004;
    localparam logic [31:0] MMIO_TMR_COUNT = 32'h0000_0008;
    localparam logic [31:0] MMIO_TMR_CMP   = 32'h0000_000C;
    localparam logic [31:0] MMIO_TMR_CTRL  = 32'h0000_0010;
    localparam logic [31:0] MMIO_TMR_STAT  = 32'h0000_0014;

    localparam int TMR_EN_BIT    = 0;
    localparam int TMR_AR_BIT    = 1;
    localparam int TMR_IRQEN_BIT = 2;

    // Member order matches the TMR_*_BIT indices (first member is the MSB).
    typedef struct packed {
        logic irqEn;
        logic autoReload;
        logic en;
    } tmr_ctrl_t;

endpackage

// File: rtl/mips_dmem_timer.sv
// Compare-match timer: COUNT/CMP/CTRL/STAT registers, match handling and W1C pending flag.
module mips_dmem_timer
    import mips_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic        sel_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;
    tmr_ctrl_t   ctrl_q, ctrl_d;
    logic        pend_q, pend_d;

    logic wrCount, wrCmp, wrCtrl, wrStat, match;

    assign wrCount = we_i && sel_i && (addr_i == MMIO_TMR_COUNT[4:0]);
    assign wrCmp   = we_i && sel_i && (addr_i == MMIO_TMR_CMP[4:0]);
    assign wrCtrl  = we_i && sel_i && (addr_i == MMIO_TMR_CTRL[4:0]);
    assign wrStat  = we_i && sel_i && (addr_i == MMIO_TMR_STAT[4:0]);
    assign match   = ctrl_q.en && (count_q == cmp_q);

    // Software writes to COUNT/CTRL take priority; a match beats a W1C clear of PEND.
    always_comb begin
        count_d = count_q;
        cmp_d   = cmp_q;
        ctrl_d  = ctrl_q;
        pend_d  = pend_q;

        if (match) begin
            if (ctrl_q.autoReload) begin
                count_d = '0;
            end else begin
                ctrl_d.en = 1'b0;
            end
        end else if (ctrl_q.en) begin
            count_d = count_q + 32'd1;
        end

        if (wrCount) count_d = wdata_i;
        if (wrCmp)   cmp_d   = wdata_i;
        if (wrCtrl) begin
            ctrl_d.en         = wdata_i[TMR_EN_BIT];
            ctrl_d.autoReload = wdata_i[TMR_AR_BIT];
            ctrl_d.irqEn      = wdata_i[TMR_IRQEN_BIT];
        end

        if (match) begin
            pend_d = 1'b1;
        end else if (wrStat && wdata_i[0]) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            cmp_q   <= '0;
            ctrl_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (sel_i) begin
            case (addr_i)
                MMIO_TMR_COUNT[4:0]: rdata_o = count_q;
                MMIO_TMR_CMP[4:0]:   rdata_o = cmp_q;
                MMIO_TMR_CTRL[4:0]:  rdata_o = {29'd0, ctrl_q};
                MMIO_TMR_STAT[4:0]:  rdata_o = {31'd0, pend_q};
                default:             rdata_o = '0;
            endcase
        end
    end

    assign irq_o = pend_q & ctrl_q.irqEn;

endmodule

// File: rtl/mips_dmem.sv
// MIPS data-memory stage: word RAM below 0x8000_0000, GPIO and optional timer above it.
// The timer is built only when MIPS_DMEM_TIMER_EN is defined; otherwise its window reads 0.
module mips_dmem
    import mips_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int GPIO_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memwrite,
    input  logic [31:0]           memaddr,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic                  timer_irq
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]           mem_q [RAM_WORDS];
    logic [GPIO_WIDTH-1:0] gpioOut_q, gpioOut_d;
    logic [GPIO_WIDTH-1:0] sync1_q, sync2_q;

    logic          isMmio;
    logic [30:0]   mmioOff;
    logic [AW-1:0] ramIdx;
    logic          gpioOutSel, gpioInSel;
    logic [31:0]   timerRdata;
    logic          unusedAddrBits;

    assign isMmio         = memaddr[31];
    assign mmioOff        = {memaddr[30:2], 2'b00};
    assign ramIdx         = memaddr[AW+1:2];
    assign gpioOutSel     = isMmio && (mmioOff == MMIO_GPIO_OUT[30:0]);
    assign gpioInSel      = isMmio && (mmioOff == MMIO_GPIO_IN[30:0]);
    assign unusedAddrBits = ^memaddr[1:0];

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (memwrite && !isMmio) begin
            mem_q[ramIdx] <= writedata;
        end
    end

    always_comb begin
        gpioOut_d = gpioOut_q;
        if (memwrite && gpioOutSel) begin
            gpioOut_d = writedata[GPIO_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gpioOut_q <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
        end else begin
            gpioOut_q <= gpioOut_d;
            sync1_q   <= gpio_in;
            sync2_q   <= sync1_q;
        end
    end

    assign gpio_out = gpioOut_q;

`ifdef MIPS_DMEM_TIMER_EN
    logic timerSel;

    assign timerSel = isMmio && (mmioOff[30:5] == 26'd0);

    mips_dmem_timer u_timer (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (memwrite),
        .sel_i   (timerSel),
        .addr_i  (mmioOff[4:0]),
        .wdata_i (writedata),
        .rdata_o (timerRdata),
        .irq_o   (timer_irq)
    );
`else
    assign timerRdata = '0;
    assign timer_irq  = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        if (!isMmio) begin
            readdata = mem_q[ramIdx];
        end else if (gpioOutSel) begin
            readdata = 32'(gpioOut_q);
        end else if (gpioInSel) begin
            readdata = 32'(sync2_q);
        end else begin
            readdata = timerRdata;
        end
    end

endmodule

// File: tb/tb_mips_dmem.sv
// Directed self-checking bench for mips_dmem; timer checks follow MIPS_DMEM_TIMER_EN.
module tb_mips_dmem;

    logic        clk;
    logic        rst;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        timer_irq;

    int testsRun    = 0;
    int testsFailed = 0;

    localparam logic [31:0] A_GPIO_OUT = 32'h8000_0000;
    localparam logic [31:0] A_GPIO_IN  = 32'h8000_0004;
    localparam logic [31:0] A_COUNT    = 32'h8000_0008;
    localparam logic [31:0] A_CMP      = 32'h8000_000C;
    localparam logic [31:0] A_CTRL     = 32'h8000_0010;
    localparam logic [31:0] A_STAT     = 32'h8000_0014;

    mips_dmem #(.RAM_WORDS(64), .GPIO_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .memwrite  (memwrite),
        .memaddr   (memaddr),
        .writedata (writedata),
        .readdata  (readdata),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One write, committed on the next rising edge; returns 1ns after that edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        memaddr   = addr;
        writedata = data;
        memwrite  = 1'b1;
        @(posedge clk);
        #1;
        memwrite  = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] expected);
        memaddr = addr;
        #1;
        checkOutput(tag, readdata, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        memwrite  = 1'b0;
        memaddr   = '0;
        writedata = '0;
        gpio_in   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("rst_gpio_out", {24'd0, gpio_out}, 32'd0);
        checkOutput("rst_irq", {31'd0, timer_irq}, 32'd0);
        readCheck("rst_rd_gpio_out", A_GPIO_OUT, 32'd0);
        readCheck("rst_rd_gpio_in", A_GPIO_IN, 32'd0);
        readCheck("rst_rd_count", A_COUNT, 32'd0);

        // RAM write, same-cycle old data, aliasing
        applyStimulus(32'h0000_0010, 32'hDEAD_BEEF);
        readCheck("ram_rd_0x10", 32'h0000_0010, 32'hDEAD_BEEF);
        readCheck("ram_alias_0x110", 32'h0000_0110, 32'hDEAD_BEEF);
        readCheck("ram_alias_high", 32'h7FFF_FF10, 32'hDEAD_BEEF);
        applyStimulus(32'h0000_0020, 32'h1111_1111);
        memaddr   = 32'h0000_0020;
        writedata = 32'h2222_2222;
        memwrite  = 1'b1;
        #1;
        checkOutput("ram_same_cycle_old", readdata, 32'h1111_1111);
        step();
        memwrite = 1'b0;
        checkOutput("ram_raw_new", readdata, 32'h2222_2222);
        readCheck("ram_other_kept", 32'h0000_0010, 32'hDEAD_BEEF);

        // GPIO
        applyStimulus(A_GPIO_OUT, 32'h0000_00A5);
        checkOutput("gpio_out_pin", {24'd0, gpio_out}, 32'h0000_00A5);
        readCheck("gpio_out_rd", A_GPIO_OUT, 32'h0000_00A5);
        gpio_in = 8'h3C;
        readCheck("gpio_in_lat0", A_GPIO_IN, 32'd0);
        step();
        readCheck("gpio_in_lat1", A_GPIO_IN, 32'd0);
        step();
        readCheck("gpio_in_lat2", A_GPIO_IN, 32'h0000_003C);
        applyStimulus(A_GPIO_IN, 32'h0000_00FF);
        readCheck("gpio_in_wr_ignored", A_GPIO_IN, 32'h0000_003C);

        // Unmapped MMIO
        applyStimulus(32'h8000_0020, 32'h1234_5678);
        readCheck("unmapped_0x20", 32'h8000_0020, 32'd0);
        readCheck("unmapped_0x18", 32'h8000_0018, 32'd0);
        readCheck("unmapped_no_side", A_GPIO_OUT, 32'h0000_00A5);

`ifdef MIPS_DMEM_TIMER_EN
        applyStimulus(A_CTRL, 32'hFFFF_FFF8);
        readCheck("ctrl_upper_zero", A_CTRL, 32'd0);

        // One-shot
        applyStimulus(A_CMP, 32'd5);
        readCheck("cmp_rd", A_CMP, 32'd5);
        applyStimulus(A_COUNT, 32'd0);
        applyStimulus(A_CTRL, 32'h0000_0005);
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 5) checkOutput("oneshot_irq_k5", {31'd0, timer_irq}, 32'd0);
        end
        checkOutput("oneshot_irq_k6", {31'd0, timer_irq}, 32'd1);
        readCheck("oneshot_count_hold", A_COUNT, 32'd5);
        readCheck("oneshot_en_clear", A_CTRL, 32'h0000_0004);
        readCheck("oneshot_pend", A_STAT, 32'd1);
        step();
        step();
        readCheck("oneshot_count_hold2", A_COUNT, 32'd5);

        // Auto-reload
        applyStimulus(A_STAT, 32'd1);
        checkOutput("w1c_clear_irq", {31'd0, timer_irq}, 32'd0);
        applyStimulus(A_CMP, 32'd3);
        applyStimulus(A_COUNT, 32'd0);
        applyStimulus(A_CTRL, 32'h0000_0007);
        for (int k = 0; k <= 5; k++) begin
            if (k == 3) checkOutput("ar_irq_k3", {31'd0, timer_irq}, 32'd0);
            if (k == 4) checkOutput("ar_irq_k4", {31'd0, timer_irq}, 32'd1);
            readCheck($sformatf("ar_count_k%0d", k), A_COUNT, 32'(k % 4));
            step();
        end
        applyStimulus(A_STAT, 32'd1);
        checkOutput("ar_w1c_clear", {31'd0, timer_irq}, 32'd0);
        applyStimulus(A_STAT, 32'd1);
        checkOutput("ar_match_beats_w1c", {31'd0, timer_irq}, 32'd1);
        readCheck("ar_stat_pend", A_STAT, 32'd1);
        readCheck("ar_count_wrapped", A_COUNT, 32'd0);

        // Reset mid-count
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("midrst_irq", {31'd0, timer_irq}, 32'd0);
        checkOutput("midrst_gpio_out", {24'd0, gpio_out}, 32'd0);
        readCheck("midrst_count", A_COUNT, 32'd0);
        readCheck("midrst_ctrl", A_CTRL, 32'd0);
        step();
        readCheck("midrst_count_stopped", A_COUNT, 32'd0);
`else
        applyStimulus(A_COUNT, 32'h1234_5678);
        readCheck("notimer_count", A_COUNT, 32'd0);
        applyStimulus(A_CMP, 32'd0);
        applyStimulus(A_CTRL, 32'h0000_0007);
        readCheck("notimer_ctrl", A_CTRL, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput("notimer_irq", {31'd0, timer_irq}, 32'd0);
        end
        readCheck("notimer_stat", A_STAT, 32'd0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("midrst_gpio_out", {24'd0, gpio_out}, 32'd0);
        readCheck("midrst_ram_kept", 32'h0000_0010, 32'hDEAD_BEEF);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mips_dmem.md
# mips_dmem

Data-memory stage directly downstream of the MIPS core's data port: it consumes `memwrite`, `memaddr` and `writedata`, and returns `readdata` in the same cycle, as the single-cycle core requires. Low addresses map to a word-addressed RAM. The MMIO window at `0x8000_0000` holds a GPIO output register, a synchronised GPIO input and a compare-match timer. The timer's interrupt output is available for a future exception path.

## Interface
- `RAM_WORDS`, default 64: RAM depth in 32-bit words; must be a power of two.
- `GPIO_WIDTH`, default 8: width of the GPIO input and output ports.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `memwrite` in 1: write strobe for the addressed word.
- `memaddr` in 32: byte address; bits [1:0] are ignored.
- `writedata` in 32: store data.
- `readdata` out 32: load data, combinational from `memaddr`.
- `gpio_in` in GPIO_WIDTH: asynchronous external inputs.
- `gpio_out` out GPIO_WIDTH: GPIO output register.
- `timer_irq` out 1: timer interrupt, level-sensitive.

## Operation
- Decode rule: `memaddr[31]=0` selects RAM; `memaddr[31]=1` selects MMIO.
- RAM index is `memaddr[log2(RAM_WORDS)+1:2]`; higher address bits are ignored, so accesses alias and wrap.
- MMIO registers, at offsets from `0x8000_0000`:
  - 0x00 GPIO_OUT: read/write.
  - 0x04 GPIO_IN: read-only.
  - 0x08 TMR_COUNT: read/write.
  - 0x0C TMR_CMP: read/write.
  - 0x10 TMR_CTRL: bit0 EN, bit1 AUTORELOAD, bit2 IRQ_EN; other bits read 0.
  - 0x14 TMR_STAT: bit0 PEND, write-1-to-clear.
- Unmapped MMIO offsets read 0; writes to them are ignored. Writes to GPIO_IN are ignored.
- GPIO_IN passes through a 2-flop synchroniser; reads return the second flop; upper read bits are zero.
- Timer counting: while EN=1, TMR_COUNT increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0.
- Timer match: when EN=1 and COUNT==CMP, at the next edge:
  - PEND is set to 1.
  - If AUTORELOAD=1, COUNT becomes 0.
  - If AUTORELOAD=0, COUNT holds its value and EN clears to 0.
- `timer_irq` = PEND & IRQ_EN, driven straight from registers (no combinational path from inputs).
- Simultaneous events:
  - A software write to COUNT or CTRL beats the timer's increment, reload or EN-clear in the same cycle.
  - A match setting PEND beats a W1C clear of PEND in the same cycle; PEND stays 1.
- Reset values:
  - `gpio_out`=0; COUNT=0, CMP=0, CTRL=0, PEND=0; `timer_irq`=0; synchroniser flops=0.
  - `readdata` reflects register reset values for MMIO addresses.
  - RAM contents are not reset.
- Reset mid-count: the timer stops, and all timer state returns to reset values on that edge.

## Timing
- Read latency is 0 cycles: `readdata` is a combinational function of `memaddr` and current state.
- Writes commit on the rising edge where `memwrite`=1. Read-after-write to the same address returns new data from the next cycle.
- A same-cycle read of the address being written returns the old data.
- `gpio_in` to GPIO_IN read value: 2 cycles of latency.
- Match to PEND/`timer_irq` high: 1 cycle after the cycle in which COUNT==CMP.

## Configuration
- `MIPS_DMEM_TIMER_EN`: when defined, the timer (offsets 0x08–0x14) is built as specified above.
- When undefined:
  - No timer registers exist.
  - Offsets 0x08–0x14 read 0 and writes to them are ignored.
  - `timer_irq` is tied to 0.
  - RAM and GPIO behaviour is unchanged.

## Structure
- `mips_pkg` gains:
  - `MMIO_BASE` = 32'h8000_0000.
  - Register offset localparams: `MMIO_GPIO_OUT`, `MMIO_GPIO_IN`, `MMIO_TMR_COUNT`, `MMIO_TMR_CMP`, `MMIO_TMR_CTRL`, `MMIO_TMR_STAT`.
  - Control bit indices: `TMR_EN_BIT`, `TMR_AR_BIT`, `TMR_IRQEN_BIT`.
  - A `tmr_ctrl_t` packed struct.
- One sub-module, `mips_dmem_timer`, contains COUNT/CMP/CTRL/PEND, the match logic and the W1C logic.
  - It is instantiated only under `MIPS_DMEM_TIMER_EN`.
- The top level contains the address decode, RAM, GPIO and the read mux.

## Test plan
- RAM write/read:
  - Write 0xDEAD_BEEF at 0x0000_0010 → reading 0x10 returns 0xDEAD_BEEF next cycle.
  - With RAM_WORDS=64, reading 0x0000_0110 (aliasing index 4) also returns it.
- GPIO:
  - Write 0x0000_00A5 to 0x8000_0000 → `gpio_out`=0xA5 after the edge.
  - Drive `gpio_in`=0x3C → a read of 0x8000_0004 returns 0x3C only from the 2nd cycle onward.
- One-shot timer:
  - Write CMP=5, then CTRL=0x5 (EN + IRQ_EN), COUNT=0.
  - → `timer_irq` rises exactly 6 cycles after EN is set, COUNT holds at 5, and CTRL.EN reads 0.
- Auto-reload:
  - Write CMP=3 and CTRL=0x7 → `timer_irq` asserts, and COUNT sequence reads 0,1,2,3,0,1… continuously.
  - W1C of STAT in the same cycle as a match → PEND stays 1.
- Reset and unmapped access:
  - Assert `rst` mid-count → the next cycle shows COUNT=0, `timer_irq`=0, `gpio_out`=0.
  - Reading 0x8000_0020 returns 0.
  - With `MIPS_DMEM_TIMER_EN` undefined, reading 0x8000_0008 returns 0 and `timer_irq` stays 0.
